// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer over a variable-latency IMEM
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        valid_f,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        flush_d,
  output logic        fetch_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD, S_ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      buffer;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      target;
  logic             timeout_hit;

  assign target      = {redirect_pc[31:2], 2'b00};
  assign timeout_hit = TO_EN && (cnt == CNT_LAST);

  // cnt measures the age of the single outstanding request, across REQ and DISCARD
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      cnt    <= '0;
      buffer <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (redirect) begin
            pc <= target;
            if (mem_rvalid) begin
              cnt <= '0;
            end else if (timeout_hit) begin
              state <= S_ERR;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= S_DISCARD;
            end
          end else if (mem_rvalid) begin
            cnt <= '0;
            if (stall_d) begin
              buffer <= mem_rdata;
              state  <= S_HOLD;
            end else begin
              pc <= pc + 32'd4;
            end
          end else if (timeout_hit) begin
            state <= S_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= S_REQ;
          end else if (!stall_d) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (redirect) pc <= target;
          if (mem_rvalid) begin
            cnt   <= '0;
            state <= S_REQ;
          end else if (timeout_hit) begin
            state <= S_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_req    = (state == S_REQ);
  assign mem_addr   = pc;
  assign pc_f       = pc;
  assign pc_plus4_f = pc + 32'd4;
  assign instr_f    = (state == S_REQ) ? mem_rdata : buffer;
  assign valid_f    = !redirect && !stall_d &&
                      (((state == S_REQ) && mem_rvalid) || (state == S_HOLD));
  assign flush_d    = redirect &&
                      ((state == S_REQ) || (state == S_HOLD) || (state == S_DISCARD));
  assign fetch_err  = (state == S_ERR);

endmodule
